// File: rtl/mips_cpu_control_fsm.sv
// Multicycle control sequencer for the MIPS CPU.
// Adds bus stalls, delay slots, HI/LO interlock and halt-on-jump.
module mips_cpu_control_fsm #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000,
  parameter int          MULT_CYCLES  = 4,
  parameter int          DIV_CYCLES   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        alu_cond,
  input  logic [31:0] jump_target,
  input  logic        waitrequest,
  output logic [31:0] pc,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        addr_sel,
  output logic        reg_write,
  output logic        hilo_write,
  output logic        muldiv_busy,
  output logic        active,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALTED = 3'd5
  } state_t;

  localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES);

  state_t cur;
  state_t nxt;
  state_t retire;

  logic [31:0] pending_target;
  logic        branch_pending;
  logic        halt_pending;
  logic        halt_armed;
  logic [5:0]  cnt;

  logic [5:0] op;
  logic [5:0] fn;
  logic       link_ri;
  logic       unused_bits;

  logic is_jump;
  logic is_branch;
  logic is_load;
  logic is_store;
  logic is_muldiv;
  logic is_div;
  logic is_mthilo;
  logic hilo_dep;
  logic wr_reg;

  logic mem_op;
  logic stall;
  logic taken;
  logic fetch_done;
  logic exec_go;

  assign op          = instr[31:26];
  assign fn          = instr[5:0];
  assign link_ri     = instr[20];
  assign unused_bits = ^{instr[25:21], instr[19:6]};

  always_comb begin
    is_jump   = 1'b0;
    is_branch = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_muldiv = 1'b0;
    is_div    = 1'b0;
    is_mthilo = 1'b0;
    hilo_dep  = 1'b0;
    wr_reg    = 1'b0;
    case (op)
      6'h00: begin
        case (fn)
          6'h08: is_jump = 1'b1;
          6'h09: begin
            is_jump = 1'b1;
            wr_reg  = 1'b1;
          end
          6'h0C, 6'h0D: ;
          6'h10, 6'h12: begin
            hilo_dep = 1'b1;
            wr_reg   = 1'b1;
          end
          6'h11, 6'h13: begin
            hilo_dep  = 1'b1;
            is_mthilo = 1'b1;
          end
          6'h18, 6'h19: begin
            hilo_dep  = 1'b1;
            is_muldiv = 1'b1;
          end
          6'h1A, 6'h1B: begin
            hilo_dep  = 1'b1;
            is_muldiv = 1'b1;
            is_div    = 1'b1;
          end
          default: wr_reg = 1'b1;
        endcase
      end
      // BLTZAL/BGEZAL link unconditionally
      6'h01: begin
        is_branch = 1'b1;
        wr_reg    = link_ri;
      end
      6'h02: is_jump = 1'b1;
      6'h03: begin
        is_jump = 1'b1;
        wr_reg  = 1'b1;
      end
      6'h04, 6'h05, 6'h06, 6'h07:
        is_branch = 1'b1;
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F:
        wr_reg = 1'b1;
      6'h20, 6'h21, 6'h22, 6'h23,
      6'h24, 6'h25, 6'h26:
        is_load = 1'b1;
      6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E:
        is_store = 1'b1;
      default: ;
    endcase
  end

  assign muldiv_busy = (cnt != 6'd0);
  assign mem_op      = is_load | is_store;
  assign stall       = (cur == EXEC) & hilo_dep & muldiv_busy;
  assign taken       = is_jump | (is_branch & alu_cond);
  assign fetch_done  = (cur == FETCH) & ~waitrequest;
  assign exec_go     = (cur == EXEC) & ~stall;
  assign retire      = halt_armed ? HALTED : FETCH;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur <= FETCH;
    end else begin
      cur <= nxt;
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      FETCH:  if (!waitrequest) nxt = DECODE;
      DECODE: nxt = EXEC;
      EXEC: begin
        unique case (1'b1)
          stall:            nxt = EXEC;
          mem_op:           nxt = MEM;
          !stall && wr_reg: nxt = WB;
          default:          nxt = retire;
        endcase
      end
      MEM: begin
        if (!waitrequest) begin
          nxt = is_load ? WB : retire;
        end
      end
      WB:     nxt = retire;
      HALTED: nxt = HALTED;
      default: nxt = FETCH;
    endcase
  end

  // Strobes are gated by reset so they drop the moment it asserts
  always_comb begin
    ir_write   = reset & fetch_done;
    mem_read   = reset & ((cur == FETCH) |
                          ((cur == MEM) & is_load));
    mem_write  = reset & (cur == MEM) & is_store;
    addr_sel   = reset & (cur == MEM);
    reg_write  = reset & (cur == WB);
    hilo_write = reset & (cur != HALTED) &
                 ((cnt == 6'd1) | (exec_go & is_mthilo));
    active     = (cur != HALTED);
    state      = cur;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc             <= RESET_VECTOR;
      pending_target <= '0;
      branch_pending <= 1'b0;
      halt_pending   <= 1'b0;
      halt_armed     <= 1'b0;
      cnt            <= '0;
    end else begin
      if (fetch_done) begin
        if (branch_pending) begin
          pc             <= pending_target;
          branch_pending <= 1'b0;
          halt_armed     <= halt_pending;
          halt_pending   <= 1'b0;
        end else begin
          pc <= pc + 32'd4;
        end
      end
      if (exec_go && taken) begin
        pending_target <= jump_target;
        branch_pending <= 1'b1;
        if (is_jump && jump_target == HALT_ADDR) begin
          halt_pending <= 1'b1;
        end
      end
      if (exec_go && is_muldiv) begin
        cnt <= is_div ? DIV_LOAD : MULT_LOAD;
      end else if (cnt != 6'd0) begin
        cnt <= cnt - 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu_control_fsm.sv
// Scoreboard bench for mips_cpu_control_fsm.
// Directed programs each end by jumping to the halt address.
module tb_mips_cpu_control_fsm;

  localparam logic [31:0] V = 32'hBFC00000;

  localparam logic [31:0] ADDIU = 32'h24080001;
  localparam logic [31:0] SW    = 32'hAC080000;
  localparam logic [31:0] LW    = 32'h8C080000;
  localparam logic [31:0] JMP   = 32'h08000000;
  localparam logic [31:0] NOP   = 32'h00000000;
  localparam logic [31:0] BEQ   = 32'h10000040;
  localparam logic [31:0] DIV   = 32'h0109001A;
  localparam logic [31:0] MULT  = 32'h01090018;
  localparam logic [31:0] MFLO  = 32'h00005012;
  localparam logic [31:0] MTHI  = 32'h01000011;
  localparam logic [31:0] JR    = 32'h03E00008;

  localparam int K_IRW  = 1;
  localparam int K_REGW = 2;
  localparam int K_MEMW = 3;
  localparam int K_MEMR = 4;
  localparam int K_HILO = 5;
  localparam int K_HALT = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = '0;
  logic        alu_cond = 1'b0;
  logic [31:0] jump_target = '0;
  logic        waitrequest;
  logic [31:0] pc;
  logic        ir_write;
  logic        mem_read;
  logic        mem_write;
  logic        addr_sel;
  logic        reg_write;
  logic        hilo_write;
  logic        muldiv_busy;
  logic        active;
  logic [2:0]  state;

  int   stall_init = 0;
  int   stall_left = 0;
  logic mem_hold = 1'b0;

  bit [31:0] imem [bit [31:0]];
  bit [31:0] tgt  [bit [31:0]];
  bit        cnd  [bit [31:0]];

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] pc;
    logic        aux;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  bit  was_halt = 1'b0;

  mips_cpu_control_fsm #(
    .RESET_VECTOR(V),
    .HALT_ADDR(32'h0),
    .MULT_CYCLES(4),
    .DIV_CYCLES(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .instr(instr),
    .alu_cond(alu_cond),
    .jump_target(jump_target),
    .waitrequest(waitrequest),
    .pc(pc),
    .ir_write(ir_write),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .addr_sel(addr_sel),
    .reg_write(reg_write),
    .hilo_write(hilo_write),
    .muldiv_busy(muldiv_busy),
    .active(active),
    .state(state)
  );

  always #5 clk = ~clk;

  assign waitrequest = (stall_left != 0) || (mem_hold && addr_sel);

  // Minimal datapath: IR plus per-instruction branch info
  always @(posedge clk) begin
    if (ir_write) begin
      instr       <= imem.exists(pc) ? imem[pc] : 32'h0;
      alu_cond    <= cnd.exists(pc) ? cnd[pc] : 1'b0;
      jump_target <= tgt.exists(pc) ? tgt[pc] : 32'h0;
    end
    if (!reset) begin
      stall_left <= stall_init;
    end else if ((mem_read || mem_write) && stall_left > 0) begin
      stall_left <= stall_left - 1;
    end
  end

  task automatic chk(string name, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic ev(int k, int c, logic [31:0] p, logic a);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.pc   = p;
    e.aux  = a;
    exp_q.push_back(e);
  endtask

  task automatic observe(int k, logic a);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected event: kind=%0d cyc=%0d pc=%h",
               k, cyc, pc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc ||
          e.pc !== pc || e.aux !== a) begin
        bad++;
        $display({"FAIL event: got kind=%0d cyc=%0d pc=%h aux=%b,",
                  " expected kind=%0d cyc=%0d pc=%h aux=%b"},
                 k, cyc, pc, a, e.kind, e.cyc, e.pc, e.aux);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      cyc = 0;
      was_halt = 1'b0;
    end else begin
      cyc++;
      if (ir_write) observe(K_IRW, addr_sel);
      if (reg_write) observe(K_REGW, mem_read | mem_write);
      if (mem_write && !waitrequest) observe(K_MEMW, addr_sel);
      if (mem_read && addr_sel && !waitrequest)
        observe(K_MEMR, addr_sel);
      if (hilo_write) observe(K_HILO, muldiv_busy);
      if (state == 3'd5 && !was_halt) observe(K_HALT, active);
      was_halt = (state == 3'd5);
    end
  end

  task automatic clr();
    imem.delete();
    tgt.delete();
    cnd.delete();
  endtask

  task automatic ld(logic [31:0] a, logic [31:0] ins,
                    logic c, logic [31:0] t);
    imem[a] = ins;
    cnd[a]  = c;
    tgt[a]  = t;
  endtask

  task automatic hold_reset_checks();
    #1;
    chk("rst pc", pc, V);
    chk("rst state", {29'd0, state}, 32'd0);
    chk("rst active", {31'd0, active}, 32'd1);
    chk("rst mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst addr_sel", {31'd0, addr_sel}, 32'd0);
    chk("rst ir_write", {31'd0, ir_write}, 32'd0);
    chk("rst reg_write", {31'd0, reg_write}, 32'd0);
    chk("rst hilo_write", {31'd0, hilo_write}, 32'd0);
    chk("rst busy", {31'd0, muldiv_busy}, 32'd0);
  endtask

  task automatic do_reset(int st);
    @(posedge clk);
    #1 reset = 1'b0;
    stall_init = st;
    hold_reset_checks();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic run_prog(string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (state == 3'd5) begin
        done = 1'b1;
        break;
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s timeout: state=%0d expected halted",
               name, state);
    end
    repeat (4) @(negedge clk);
    chk({name, " pc frozen"}, pc, 32'h0);
    chk({name, " active"}, {31'd0, active}, 32'd0);
    chk({name, " drain"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // ADDIU, SW, then J 0 with NOP in its delay slot
    clr();
    ld(V,      ADDIU, 1'b0, 32'h0);
    ld(V + 4,  SW,    1'b0, 32'h0);
    ld(V + 8,  JMP,   1'b0, 32'h0);
    ld(V + 12, NOP,   1'b0, 32'h0);
    ev(K_IRW,  1,  V,      1'b0);
    ev(K_REGW, 4,  V + 4,  1'b0);
    ev(K_IRW,  5,  V + 4,  1'b0);
    ev(K_MEMW, 8,  V + 8,  1'b1);
    ev(K_IRW,  9,  V + 8,  1'b0);
    ev(K_IRW,  12, V + 12, 1'b0);
    ev(K_REGW, 15, 32'h0,  1'b0);
    ev(K_HALT, 16, 32'h0,  1'b0);
    do_reset(0);
    run_prog("alu_sw");

    // Stalled first fetch, not-taken BEQ, then halt
    clr();
    ld(V,     BEQ,  1'b0, V + 32'h100);
    ld(V + 4, JMP,  1'b0, 32'h0);
    ld(V + 8, NOP,  1'b0, 32'h0);
    ev(K_IRW,  4,  V,     1'b0);
    ev(K_IRW,  7,  V + 4, 1'b0);
    ev(K_IRW,  10, V + 8, 1'b0);
    ev(K_REGW, 13, 32'h0, 1'b0);
    ev(K_HALT, 14, 32'h0, 1'b0);
    do_reset(3);
    run_prog("fetch_wait");

    // Taken BEQ: delay slot first, then target
    clr();
    ld(V,           BEQ, 1'b1, V + 32'h100);
    ld(V + 4,       NOP, 1'b0, 32'h0);
    ld(V + 32'h100, JMP, 1'b0, 32'h0);
    ld(V + 32'h104, NOP, 1'b0, 32'h0);
    ev(K_IRW,  1,  V,           1'b0);
    ev(K_IRW,  4,  V + 4,       1'b0);
    ev(K_REGW, 7,  V + 32'h100, 1'b0);
    ev(K_IRW,  8,  V + 32'h100, 1'b0);
    ev(K_IRW,  11, V + 32'h104, 1'b0);
    ev(K_REGW, 14, 32'h0,       1'b0);
    ev(K_HALT, 15, 32'h0,       1'b0);
    do_reset(0);
    run_prog("beq_taken");

    // DIV then MFLO interlock
    clr();
    ld(V,      DIV,  1'b0, 32'h0);
    ld(V + 4,  MFLO, 1'b0, 32'h0);
    ld(V + 8,  JMP,  1'b0, 32'h0);
    ld(V + 12, NOP,  1'b0, 32'h0);
    ev(K_IRW,  1,  V,      1'b0);
    ev(K_IRW,  4,  V + 4,  1'b0);
    ev(K_HILO, 35, V + 8,  1'b1);
    ev(K_REGW, 37, V + 8,  1'b0);
    ev(K_IRW,  38, V + 8,  1'b0);
    ev(K_IRW,  41, V + 12, 1'b0);
    ev(K_REGW, 44, 32'h0,  1'b0);
    ev(K_HALT, 45, 32'h0,  1'b0);
    do_reset(0);
    run_prog("div_mflo");

    // JR to halt address with ADDIU in delay slot
    clr();
    ld(V,     JR,    1'b0, 32'h0);
    ld(V + 4, ADDIU, 1'b0, 32'h0);
    ev(K_IRW,  1, V,     1'b0);
    ev(K_IRW,  4, V + 4, 1'b0);
    ev(K_REGW, 7, 32'h0, 1'b0);
    ev(K_HALT, 8, 32'h0, 1'b0);
    do_reset(0);
    run_prog("jr_halt");

    // LW latency, MULT then stalled MTHI
    clr();
    ld(V,      LW,   1'b0, 32'h0);
    ld(V + 4,  MULT, 1'b0, 32'h0);
    ld(V + 8,  MTHI, 1'b0, 32'h0);
    ld(V + 12, JMP,  1'b0, 32'h0);
    ld(V + 16, NOP,  1'b0, 32'h0);
    ev(K_IRW,  1,  V,      1'b0);
    ev(K_MEMR, 4,  V + 4,  1'b1);
    ev(K_REGW, 5,  V + 4,  1'b0);
    ev(K_IRW,  6,  V + 4,  1'b0);
    ev(K_IRW,  9,  V + 8,  1'b0);
    ev(K_HILO, 12, V + 12, 1'b1);
    ev(K_HILO, 13, V + 12, 1'b0);
    ev(K_IRW,  14, V + 12, 1'b0);
    ev(K_IRW,  17, V + 16, 1'b0);
    ev(K_REGW, 20, 32'h0,  1'b0);
    ev(K_HALT, 21, 32'h0,  1'b0);
    do_reset(0);
    run_prog("lw_mult_mthi");

    // Reset asserted while a store is stalled in MEM
    clr();
    ld(V, SW, 1'b0, 32'h0);
    mem_hold = 1'b1;
    ev(K_IRW, 1, V, 1'b0);
    do_reset(0);
    for (int i = 0; i < 50 && state != 3'd3; i++) begin
      @(negedge clk);
    end
    chk("reach mem", {29'd0, state}, 32'd3);
    repeat (3) @(negedge clk);
    #2;
    chk("mid mem_write", {31'd0, mem_write}, 32'd1);
    chk("mid addr_sel", {31'd0, addr_sel}, 32'd1);
    reset = 1'b0;
    #1;
    chk("async mem_write", {31'd0, mem_write}, 32'd0);
    chk("async addr_sel", {31'd0, addr_sel}, 32'd0);
    chk("async state", {29'd0, state}, 32'd0);
    chk("async pc", pc, V);
    chk("async drain", exp_q.size(), 32'd0);
    exp_q.delete();
    clr();
    ld(V,     JMP, 1'b0, 32'h0);
    ld(V + 4, NOP, 1'b0, 32'h0);
    mem_hold = 1'b0;
    ev(K_IRW,  1, V,     1'b0);
    ev(K_IRW,  4, V + 4, 1'b0);
    ev(K_REGW, 7, 32'h0, 1'b0);
    ev(K_HALT, 8, 32'h0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    run_prog("mid_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
